acc_stack_unit: RTL and testbench
=================================

Name: acc_stack_unit

Overview:
- Parametrised successor to the processor's single accumulator: a W-bit accumulator with generalised immediate loading (slot-indexed or shift-in) and a DEPTH-entry save/restore LIFO.
- Sits in the datapath between the register file, the ALU and the control decoder.
- Adds push, pop and exchange of the accumulator for subroutine and scratch use.
- Exports zero, stack-full and stack-empty flags, plus a sticky stack-error flag.

Parameters:
- W, 8, accumulator and stack entry width; must be a multiple of IMM_W.
- IMM_W, 4, immediate field width.
- DEPTH, 4, LIFO entries; must be ≥2.

Ports:
- clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Write_En  in  1  enables an accumulator source write this cycle
- Src_Sel  in  2  0=Reg, 1=ALU, 2=Imm slot, 3=Imm shift
- RegInput  in  W  register-file operand
- ALUInput  in  W  ALU result
- Imm_in  in  IMM_W  immediate field
- Imm_Slot  in  clog2(W/IMM_W)  slot index for Src_Sel=2
- Push  in  1  save accumulator to LIFO
- Pop  in  1  restore accumulator from LIFO
- Err_Clr  in  1  clears Stack_Err
- DataOut  out  W  accumulator value (registered)
- Zero  out  1  DataOut == 0 (combinational from register)
- Stack_Full  out  1  count == DEPTH
- Stack_Empty  out  1  count == 0
- Stack_Err  out  1  sticky overflow/underflow indicator
- Depth_Cnt  out  clog2(DEPTH+1)  current entry count

Behaviour:
- Reset (Reset=0, async):
  - DataOut=0, count=0, Stack_Err=0.
  - Zero=1, Stack_Empty=1, Stack_Full=0.
  - LIFO contents are don't-care.
  - Reset mid-operation aborts any op; nothing is committed that edge.
- Source writes (Write_En=1, neither Push nor Pop effective): acc updated on the next edge. Latency 1 cycle.
  - Src 0: acc <= RegInput.
  - Src 1: acc <= ALUInput.
  - Src 2: acc[Imm_Slot*IMM_W +: IMM_W] <= Imm_in; other bits are preserved. An out-of-range Imm_Slot (only possible when W/IMM_W is not a power of two) is a no-op.
  - Src 3: acc <= {acc[W-IMM_W-1:0], Imm_in}, shifting left by IMM_W.
- Push only (Pop=0), with count<DEPTH:
  - mem[count] <= acc before the edge; count+1.
  - If Write_En=1 on the same edge, acc takes the source value. The saved entry is the old value.
- Pop only (Push=0), with count>0:
  - acc <= mem[count-1]; count-1.
  - Pop overrides Write_En; the source write is dropped.
- Push & Pop together (exchange):
  - With count>0: mem[count-1] <= acc and acc <= mem[count-1]; count unchanged; Write_En ignored.
  - With count==0: counts as underflow.
- Errors:
  - Push with count==DEPTH is an overflow. Pop or exchange with count==0 is an underflow.
  - On an error, LIFO and count are unchanged. A Write_En source write still applies on overflow and is dropped on underflow.
  - Stack_Err is set on the edge of the error.
  - Err_Clr clears Stack_Err; if an error and Err_Clr occur on the same edge, set wins.
- Flags:
  - Stack_Full, Stack_Empty, Depth_Cnt and Zero derive from registered state.
  - No same-cycle bypass: a pop result is visible on DataOut the cycle after the edge.

Decomposition:
- Package acc_pkg:
  - src_sel_e enum (SRC_REG, SRC_ALU, SRC_IMM_SLOT, SRC_IMM_SHIFT).
  - Width helper constants: SLOTS=W/IMM_W, PTR_W=clog2(DEPTH+1).
- Sub-module acc_lifo(W, DEPTH):
  - Storage array and count register.
  - Push/pop/exchange inputs, top-of-stack read, full/empty/err_event outputs.
  - Asynchronous active-low reset of count only.
- Top-level acc_stack_unit: accumulator register, source mux, immediate slot/shift logic, priority resolution, sticky error.

Test Plan (W=8, IMM_W=4, DEPTH=4):
- Reset then release; Src=0, RegInput=5A -> DataOut=5A next cycle, Zero=0. Src=1, ALUInput=A5 -> A5.
- Acc=A5; Src=2 slot0 Imm=F -> AF; then slot1 Imm=C -> CF. Acc=00; Src=3 with Imm=1 then Imm=2 -> 01, then 12.
- Push 11, 22, 33, 44 -> Stack_Full=1, Depth_Cnt=4. A fifth Push -> Stack_Err=1, count stays 4. Err_Clr -> Stack_Err=0.
- Pop x4 -> DataOut 44, 33, 22, 11 on successive cycles, then Stack_Empty=1. A further Pop -> Stack_Err=1, DataOut stays 11.
- Acc=77, top=99, Push&Pop -> DataOut=99 and top=77, count unchanged. Push with Write_En Src=0 RegInput=3C, acc=77 -> stored 77, DataOut=3C.
- Assert Reset mid-push with count=2 -> DataOut=0, Depth_Cnt=0, Stack_Empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types and width helpers for the accumulator/stack unit.
package acc_pkg;

    typedef enum logic [1:0] {
        SRC_REG       = 2'd0,
        SRC_ALU       = 2'd1,
        SRC_IMM_SLOT  = 2'd2,
        SRC_IMM_SHIFT = 2'd3
    } src_sel_e;

    localparam int DEF_W     = 8;
    localparam int DEF_IMM_W = 4;
    localparam int DEF_DEPTH = 4;

    function automatic int slots_of(input int w, input int imm_w);
        return w / imm_w;
    endfunction

    // A single slot still needs a one-bit select port.
    function automatic int slot_w_of(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

    function automatic int ptr_w_of(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int SLOTS = slots_of(DEF_W, DEF_IMM_W);
    localparam int PTR_W = ptr_w_of(DEF_DEPTH);

endpackage

// File: rtl/acc_lifo.sv
// Save/restore LIFO for the accumulator: push, pop and exchange of the top entry.
module acc_lifo
    import acc_pkg::*;
#(
    parameter  int W     = DEF_W,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int CNT_W = ptr_w_of(DEPTH),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     wr_data_i,
    output logic [W-1:0]     top_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             load_o,
    output logic             underflow_o,
    output logic             err_event_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [IDX_W-1:0] top_idx_s;
    logic             overflow_s;

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == {CNT_W{1'b0}});
    assign count_o     = count_q;
    assign top_o       = mem_q[top_idx_s];
    assign err_event_o = overflow_s | underflow_o;

    // Stack operation decode: next count, storage update and outcome flags.
    always_comb begin
        mem_d       = mem_q;
        count_d     = count_q;
        load_o      = 1'b0;
        underflow_o = 1'b0;
        overflow_s  = 1'b0;
        if (empty_o) begin
            top_idx_s = {IDX_W{1'b0}};
        end else begin
            top_idx_s = IDX_W'(count_q - CNT_W'(1));
        end
        case ({push_i, pop_i})
            2'b11: begin
                if (!empty_o) begin
                    mem_d[top_idx_s] = wr_data_i;
                    load_o           = 1'b1;
                end else begin
                    underflow_o = 1'b1;
                end
            end
            2'b10: begin
                if (!full_o) begin
                    mem_d[IDX_W'(count_q)] = wr_data_i;
                    count_d                = count_q + CNT_W'(1);
                end else begin
                    overflow_s = 1'b1;
                end
            end
            2'b01: begin
                if (!empty_o) begin
                    count_d = count_q - CNT_W'(1);
                    load_o  = 1'b1;
                end else begin
                    underflow_o = 1'b1;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Entry count; only the count is reset, stored entries are don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/acc_stack_unit.sv
// W-bit accumulator with register/ALU/immediate sources, a save/restore LIFO
// and a sticky stack-error flag.
module acc_stack_unit
    import acc_pkg::*;
#(
    parameter  int W       = DEF_W,
    parameter  int IMM_W   = DEF_IMM_W,
    parameter  int DEPTH   = DEF_DEPTH,
    localparam int N_SLOTS = slots_of(W, IMM_W),
    localparam int SLOT_W  = slot_w_of(N_SLOTS),
    localparam int CNT_W   = ptr_w_of(DEPTH)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Write_En,
    input  logic [1:0]        Src_Sel,
    input  logic [W-1:0]      RegInput,
    input  logic [W-1:0]      ALUInput,
    input  logic [IMM_W-1:0]  Imm_in,
    input  logic [SLOT_W-1:0] Imm_Slot,
    input  logic              Push,
    input  logic              Pop,
    input  logic              Err_Clr,
    output logic [W-1:0]      DataOut,
    output logic              Zero,
    output logic              Stack_Full,
    output logic              Stack_Empty,
    output logic              Stack_Err,
    output logic [CNT_W-1:0]  Depth_Cnt
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic         err_q;
    logic         err_d;
    logic [W-1:0] slot_val_s;
    logic [W-1:0] shift_val_s;
    logic [W-1:0] src_val_s;
    logic [W-1:0] top_s;
    logic         load_s;
    logic         underflow_s;
    logic         err_event_s;

    acc_lifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk         (clk),
        .rst_n       (Reset),
        .push_i      (Push),
        .pop_i       (Pop),
        .wr_data_i   (acc_q),
        .top_o       (top_s),
        .count_o     (Depth_Cnt),
        .full_o      (Stack_Full),
        .empty_o     (Stack_Empty),
        .load_o      (load_s),
        .underflow_o (underflow_s),
        .err_event_o (err_event_s)
    );

    assign DataOut   = acc_q;
    assign Zero      = (acc_q == {W{1'b0}});
    assign Stack_Err = err_q;

    // Immediate forms; an out-of-range slot index matches no slot and is a no-op.
    always_comb begin
        slot_val_s  = acc_q;
        shift_val_s = W'({acc_q, Imm_in});
        for (int i = 0; i < N_SLOTS; i++) begin
            slot_val_s[i*IMM_W +: IMM_W] = (Imm_Slot == SLOT_W'(i)) ?
                                           Imm_in : acc_q[i*IMM_W +: IMM_W];
        end
    end

    // Source selection for accumulator writes.
    always_comb begin
        src_val_s = acc_q;
        case (Src_Sel)
            SRC_REG:       src_val_s = RegInput;
            SRC_ALU:       src_val_s = ALUInput;
            SRC_IMM_SLOT:  src_val_s = slot_val_s;
            SRC_IMM_SHIFT: src_val_s = shift_val_s;
            default:       src_val_s = acc_q;
        endcase
    end

    // Priority: a restore beats everything, an underflow drops the source write.
    always_comb begin
        if (load_s) begin
            acc_d = top_s;
        end else if (underflow_s) begin
            acc_d = acc_q;
        end else if (Write_En) begin
            acc_d = src_val_s;
        end else begin
            acc_d = acc_q;
        end
        if (err_event_s) begin
            err_d = 1'b1;
        end else if (Err_Clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Accumulator and sticky error registers.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            acc_q <= {W{1'b0}};
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_acc_stack_unit.sv
// Directed plus randomized checks of acc_stack_unit against a queue-based model.
module tb_acc_stack_unit;

    localparam int W     = 8;
    localparam int IMM_W = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             Reset;
    logic             Write_En;
    logic [1:0]       Src_Sel;
    logic [W-1:0]     RegInput;
    logic [W-1:0]     ALUInput;
    logic [IMM_W-1:0] Imm_in;
    logic [0:0]       Imm_Slot;
    logic             Push;
    logic             Pop;
    logic             Err_Clr;
    logic [W-1:0]     DataOut;
    logic             Zero;
    logic             Stack_Full;
    logic             Stack_Empty;
    logic             Stack_Err;
    logic [2:0]       Depth_Cnt;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_acc;
    logic [W-1:0] m_stk[$];
    bit           m_err;

    always #5 clk = ~clk;

    acc_stack_unit #(.W(W), .IMM_W(IMM_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .Write_En    (Write_En),
        .Src_Sel     (Src_Sel),
        .RegInput    (RegInput),
        .ALUInput    (ALUInput),
        .Imm_in      (Imm_in),
        .Imm_Slot    (Imm_Slot),
        .Push        (Push),
        .Pop         (Pop),
        .Err_Clr     (Err_Clr),
        .DataOut     (DataOut),
        .Zero        (Zero),
        .Stack_Full  (Stack_Full),
        .Stack_Empty (Stack_Empty),
        .Stack_Err   (Stack_Err),
        .Depth_Cnt   (Depth_Cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".acc"},   32'(DataOut),     32'(m_acc));
        chk({tag, ".cnt"},   32'(Depth_Cnt),   32'(m_stk.size()));
        chk({tag, ".zero"},  32'(Zero),        32'(m_acc == 8'h00));
        chk({tag, ".full"},  32'(Stack_Full),  32'(m_stk.size() == DEPTH));
        chk({tag, ".empty"}, 32'(Stack_Empty), 32'(m_stk.size() == 0));
        chk({tag, ".err"},   32'(Stack_Err),   32'(m_err));
    endtask

    task automatic step(input bit we, input logic [1:0] src, input logic [7:0] rv,
                        input logic [7:0] av, input logic [3:0] imm, input logic slot,
                        input bit psh, input bit pp, input bit clr, input string tag);
        logic [7:0] nv;
        logic [7:0] tmp;
        bit         ev;
        @(negedge clk);
        Write_En = we; Src_Sel = src; RegInput = rv; ALUInput = av;
        Imm_in = imm; Imm_Slot = slot; Push = psh; Pop = pp; Err_Clr = clr;
        case (src)
            2'd0: nv = rv;
            2'd1: nv = av;
            2'd2: begin nv = m_acc; nv[slot*4 +: 4] = imm; end
            default: nv = {m_acc[3:0], imm};
        endcase
        ev = 1'b0;
        if (psh && pp) begin
            if (m_stk.size() > 0) begin
                tmp = m_stk[m_stk.size()-1];
                m_stk[m_stk.size()-1] = m_acc;
                m_acc = tmp;
            end else begin
                ev = 1'b1;
            end
        end else if (psh) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(m_acc);
            else ev = 1'b1;
            if (we) m_acc = nv;
        end else if (pp) begin
            if (m_stk.size() > 0) m_acc = m_stk.pop_back();
            else ev = 1'b1;
        end else if (we) begin
            m_acc = nv;
        end
        if (ev) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        @(posedge clk);
        #1;
        chk_model(tag);
    endtask

    initial begin
        Reset = 1'b0; Write_En = 1'b0; Src_Sel = 2'd0; RegInput = 8'h00; ALUInput = 8'h00;
        Imm_in = 4'h0; Imm_Slot = 1'b0; Push = 1'b0; Pop = 1'b0; Err_Clr = 1'b0;
        m_acc = 8'h00; m_err = 1'b0;
        #12;
        chk("rst.acc", 32'(DataOut), 32'h0);
        chk("rst.zero", 32'(Zero), 32'h1);
        chk("rst.empty", 32'(Stack_Empty), 32'h1);
        chk("rst.full", 32'(Stack_Full), 32'h0);
        chk("rst.err", 32'(Stack_Err), 32'h0);
        chk("rst.cnt", 32'(Depth_Cnt), 32'h0);
        @(negedge clk);
        Reset = 1'b1;

        // Source writes
        step(1'b1, 2'd0, 8'h5A, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, "reg");
        chk("reg.val", 32'(DataOut), 32'h5A);
        chk("reg.zero", 32'(Zero), 32'h0);
        step(1'b1, 2'd1, 8'h00, 8'hA5, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, "alu");
        chk("alu.val", 32'(DataOut), 32'hA5);
        step(1'b1, 2'd2, 8'h00, 8'h00, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, "slot0");
        chk("slot0.val", 32'(DataOut), 32'hAF);
        step(1'b1, 2'd2, 8'h00, 8'h00, 4'hC, 1'b1, 1'b0, 1'b0, 1'b0, "slot1");
        chk("slot1.val", 32'(DataOut), 32'hCF);
        step(1'b1, 2'd0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, "clr0");
        step(1'b1, 2'd3, 8'h00, 8'h00, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, "shf1");
        chk("shf1.val", 32'(DataOut), 32'h01);
        step(1'b1, 2'd3, 8'h00, 8'h00, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, "shf2");
        chk("shf2.val", 32'(DataOut), 32'h12);

        // Fill to overflow, then drain to underflow
        step(1'b1, 2'd0, 8'h11, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, "ld11");
        step(1'b1, 2'd0, 8'h22, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, "push11");
        step(1'b1, 2'd0, 8'h33, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, "push22");
        step(1'b1, 2'd0, 8'h44, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, "push33");
        step(1'b0, 2'd0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, "push44");
        chk("full.flag", 32'(Stack_Full), 32'h1);
        chk("full.cnt", 32'(Depth_Cnt), 32'h4);
        step(1'b0, 2'd0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, "ovf");
        chk("ovf.err", 32'(Stack_Err), 32'h1);
        chk("ovf.cnt", 32'(Depth_Cnt), 32'h4);
        step(1'b0, 2'd0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, "errclr");
        chk("errclr.err", 32'(Stack_Err), 32'h0);
        step(1'b0, 2'd0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, "pop44");
        chk("pop44.val", 32'(DataOut), 32'h44);
        step(1'b1, 2'd0, 8'hEE, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, "pop33");
        chk("pop33.val", 32'(DataOut), 32'h33);
        step(1'b0, 2'd0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, "pop22");
        step(1'b0, 2'd0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, "pop11");
        chk("pop11.val", 32'(DataOut), 32'h11);
        chk("pop11.empty", 32'(Stack_Empty), 32'h1);
        step(1'b1, 2'd0, 8'hEE, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, "udf");
        chk("udf.err", 32'(Stack_Err), 32'h1);
        chk("udf.val", 32'(DataOut), 32'h11);
        step(1'b0, 2'd0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, "errclr2");

        // Exchange and push-with-write
        step(1'b1, 2'd0, 8'h99, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, "ld99");
        step(1'b1, 2'd0, 8'h77, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, "push99");
        step(1'b1, 2'd0, 8'h55, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, "xchg");
        chk("xchg.val", 32'(DataOut), 32'h99);
        chk("xchg.cnt", 32'(Depth_Cnt), 32'h1);
        step(1'b0, 2'd0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, "xchgtop");
        chk("xchgtop.val", 32'(DataOut), 32'h77);
        step(1'b1, 2'd0, 8'h3C, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, "pushwr");
        chk("pushwr.val", 32'(DataOut), 32'h3C);
        step(1'b0, 2'd0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, "pushwrpop");
        chk("pushwrpop.val", 32'(DataOut), 32'h77);

        // Asynchronous reset in the middle of a push
        step(1'b0, 2'd0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, "pre1");
        step(1'b1, 2'd0, 8'h6B, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, "pre2");
        @(negedge clk);
        Push = 1'b1; Write_En = 1'b0;
        #2 Reset = 1'b0;
        #1;
        chk("arst.acc", 32'(DataOut), 32'h0);
        chk("arst.cnt", 32'(Depth_Cnt), 32'h0);
        chk("arst.empty", 32'(Stack_Empty), 32'h1);
        chk("arst.zero", 32'(Zero), 32'h1);
        m_acc = 8'h00; m_stk.delete(); m_err = 1'b0;
        @(negedge clk);
        Push = 1'b0; Reset = 1'b1;
        #1;
        chk_model("arst.rel");

        // Randomized operations against the model
        for (int i = 0; i < 400; i++) begin
            int  op;
            bit  psh;
            bit  pp;
            op  = int'($urandom_range(0, 7));
            psh = (op <= 2) || (op == 5);
            pp  = (op == 3) || (op == 4) || (op == 5);
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom()),
                 8'($urandom()), 4'($urandom()), 1'($urandom_range(0, 1)),
                 psh, pp, ($urandom_range(0, 7) == 0), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
